surf_scan_sequencer: RTL and testbench
======================================

Name: surf_scan_sequencer

Overview:
- Sequences one plane-surface computation from a radius sample buffer.
- Accepts a start command (base address, sample count) and reads the samples from a 1-cycle-latency sample RAM.
- Streams them as an unbroken enable/radius burst into the plane-surface calculator, waits for its accumulator pipeline to drain, then captures the result.
- Presents the result on a valid/ready output. Sits between the scan-control logic and the calculator.

Parameters:
- AW, 10, sample RAM address width; addresses wrap modulo 2^AW.
- NW, 11, width of num_samples.
- DRAIN_CYCLES, 8, number of cycles waited after the last calc_en before calc_surf is sampled; must be ≥ calculator latency + 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- start  in  1  command strobe; accepted only in IDLE
- base_addr  in  AW  first sample address
- num_samples  in  NW  samples to stream
- busy  out  1  high from command accept until result handshake completes
- mem_rd_en  out  1  sample RAM read enable
- mem_addr  out  AW  sample RAM address
- mem_rdata  in  16  radius; valid 1 cycle after mem_rd_en
- calc_en  out  1  calculator enable
- calc_radius  out  16  calculator radius input
- calc_surf  in  32  calculator result
- res_valid  out  1  result valid
- res_ready  in  1  result consumer ready
- res_surf  out  32  captured surface
- res_err  out  1  command rejected (num_samples < 2)

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset forces state IDLE and clears all outputs: busy, mem_rd_en, calc_en, res_valid, res_err = 0; res_surf, mem_addr, calc_radius = 0.
- States and transitions:
  - IDLE: start=1 latches base_addr/num_samples and sets busy=1 next cycle.
    - num_samples ≥ 2 → STREAM.
    - Otherwise → OUT with res_err=1, res_surf=0; no RAM or calculator activity.
  - STREAM: mem_rd_en=1 for exactly N consecutive cycles; mem_addr = base_addr + i, i = 0..N-1, AW-bit wrap. Then → DRAIN.
  - Read-valid pipeline: calc_en = mem_rd_en delayed 1 cycle, and calc_radius = mem_rdata.
    - calc_en is therefore high for exactly N consecutive cycles, starting 2 cycles after the start-accept edge.
    - calc_en must never drop mid-burst, because the calculator resets its accumulator whenever its enable falls.
  - DRAIN: a counter starts on the first cycle calc_en is low and runs DRAIN_CYCLES cycles. On terminal count, res_surf ← calc_surf → OUT.
  - OUT: res_valid=1, holding res_surf/res_err stable until res_ready=1. On the handshake edge: res_valid=0, busy=0 → IDLE.
    - res_ready high before res_valid has no effect.
- start while busy: ignored, no queuing. start coincident with the OUT handshake edge: ignored; accepted from the following cycle.
- Reset mid-STREAM/DRAIN: calc_en and mem_rd_en are low on the next cycle; the result is discarded; no res_valid is produced.
- Maximum command N = 2^NW − 1. Zero-count sample indices never alias; the index counter is NW bits.

Optional Feature:
- Macro SURF_SEQ_CLOSE_LOOP_EN.
- Defined: the first sample read is held in a register. After the N-th sample, one extra calc_en cycle presents that held radius, closing the polygon. The burst is N+1 cycles, with no extra RAM read (mem_rd_en stays N cycles).
- Undefined: the burst is exactly N cycles and there is no hold register.

Test Plan:
- The calculator stub outputs the 32-bit sum of radii seen while calc_en is high.
- Basic: RAM[0..3]={10,20,30,40}, start base=0, N=4.
  - calc_en high exactly 4 cycles at start+2..start+5, radius 10,20,30,40.
  - res_valid after DRAIN, res_surf=100, res_err=0.
  - With SURF_SEQ_CLOSE_LOOP_EN: 5 cycles, res_surf=110.
- Wrap: AW=10, base=1022, N=4 → mem_addr sequence 1022,1023,0,1 with contiguous calc_en.
- Reject: start with N=1 → no mem_rd_en/calc_en; res_valid with res_err=1, res_surf=0. Repeat with N=0 → same response.
- Backpressure/overlap:
  - res_ready held 0 for 20 cycles → res_valid and res_surf stable throughout, busy=1.
  - start pulsed during STREAM and during OUT → ignored, no second burst.
  - After the handshake, a new start is accepted.
- Reset mid-burst: rst at the 3rd calc_en cycle of N=8 → calc_en=0 next cycle, busy=0, no res_valid for 50 cycles. A following command N=2 completes with the correct sum.

Source files
------------

// File: rtl/surf_scan_sequencer.sv
// Streams a contiguous sample burst from a 1-cycle RAM into the plane-surface calculator and returns its result.
// Optional closing sample: define SURF_SEQ_CLOSE_LOOP_EN to replay the first radius after the last one.
module surf_scan_sequencer #(
  parameter int AW           = 10,
  parameter int NW           = 11,
  parameter int DRAIN_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [NW-1:0] num_samples,
  output logic          busy,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [15:0]   mem_rdata,
  output logic          calc_en,
  output logic [15:0]   calc_radius,
  input  logic [31:0]   calc_surf,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [31:0]   res_surf,
  output logic          res_err,
  output logic [1:0]    dbg_state
);

  // Result handshake: res_surf/res_err are held while res_valid=1 and res_ready=0; the transfer
  // happens on the edge where both are high, and res_ready while res_valid=0 is ignored.

  localparam int DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_OUT} state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            rd_en_q, rd_en_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DCW-1:0]  drain_q, drain_d;
  logic            res_valid_q, res_valid_d;
  logic [31:0]     res_surf_q, res_surf_d;
  logic            res_err_q, res_err_d;
  logic            calc_en_q;
  logic            calc_en_w;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      n_q         <= '0;
      drain_q     <= '0;
      res_valid_q <= 1'b0;
      res_surf_q  <= '0;
      res_err_q   <= 1'b0;
      calc_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      drain_q     <= drain_d;
      res_valid_q <= res_valid_d;
      res_surf_q  <= res_surf_d;
      res_err_q   <= res_err_d;
      // Read data lands one cycle after the read, so the enable simply trails the read strobe.
      calc_en_q   <= rd_en_q;
    end
  end

`ifdef SURF_SEQ_CLOSE_LOOP_EN
  logic        close_q;
  logic        first_q;
  logic [15:0] hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      close_q <= 1'b0;
      first_q <= 1'b0;
      hold_q  <= '0;
    end else begin
      // Last regular calc_en cycle is the only one with calc_en_q high and the read strobe already low.
      close_q <= calc_en_q && !rd_en_q;
      if (state_q == S_IDLE && start) first_q <= 1'b1;
      else if (calc_en_q)             first_q <= 1'b0;
      if (calc_en_q && first_q) hold_q <= mem_rdata;
    end
  end

  assign calc_en_w   = calc_en_q | close_q;
  assign calc_radius = close_q ? hold_q : (calc_en_q ? mem_rdata : 16'd0);
`else
  assign calc_en_w   = calc_en_q;
  assign calc_radius = calc_en_q ? mem_rdata : 16'd0;
`endif

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    rd_en_d     = rd_en_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    drain_d     = drain_q;
    res_valid_d = res_valid_q;
    res_surf_d  = res_surf_q;
    res_err_d   = res_err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          n_d    = num_samples;
          if (num_samples > NW'(1)) begin
            rd_en_d = 1'b1;
            addr_d  = base_addr;
            cnt_d   = NW'(1);
            state_d = S_STREAM;
          end else begin
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
            res_surf_d  = '0;
            state_d     = S_OUT;
          end
        end
      end
      S_STREAM: begin
        if (cnt_q == n_q) begin
          rd_en_d = 1'b0;
          drain_d = '0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q + NW'(1);
        end
      end
      S_DRAIN: begin
        // Drain time is counted only once the burst (including any closing sample) has ended.
        if (!calc_en_w) begin
          if (drain_q == DRAIN_LAST) begin
            res_surf_d  = calc_surf;
            res_err_d   = 1'b0;
            res_valid_d = 1'b1;
            state_d     = S_OUT;
          end else begin
            drain_d = drain_q + DCW'(1);
          end
        end
      end
      S_OUT: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          res_err_d   = 1'b0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = busy_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign calc_en   = calc_en_w;
  assign res_valid = res_valid_q;
  assign res_surf  = res_surf_q;
  assign res_err   = res_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_surf_scan_sequencer.sv
// Bench for surf_scan_sequencer: sample RAM and summing calculator stub, table vectors, reset corner, random commands.
module tb_surf_scan_sequencer;

`ifdef SURF_SEQ_CLOSE_LOOP_EN
  localparam int CLOSE = 1;
`else
  localparam int CLOSE = 0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [10:0] num_samples = '0;
  logic        busy, mem_rd_en, calc_en, res_valid, res_err;
  logic [9:0]  mem_addr;
  logic [15:0] mem_rdata, calc_radius;
  logic [31:0] calc_surf, res_surf;
  logic        res_ready = 1'b0;
  logic [1:0]  dbg_state;

  surf_scan_sequencer #(.AW(10), .NW(11), .DRAIN_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_samples(num_samples),
    .busy(busy), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .calc_en(calc_en), .calc_radius(calc_radius), .calc_surf(calc_surf),
    .res_valid(res_valid), .res_ready(res_ready), .res_surf(res_surf), .res_err(res_err),
    .dbg_state(dbg_state)
  );

  // sample RAM with one cycle of read latency
  logic [15:0] ram [1024];
  always @(posedge clk) if (mem_rd_en) mem_rdata <= ram[mem_addr];

  // calculator stub: sum of radii over one enable burst, restarted when the enable rises
  logic        en_d1 = 1'b0;
  logic [31:0] acc = '0;
  always @(posedge clk) begin
    en_d1 <= calc_en;
    if (calc_en) acc <= (en_d1 ? acc : 32'd0) + {16'd0, calc_radius};
  end
  assign calc_surf = acc;

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  logic [9:0]  exp_addr_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_sum(input logic [9:0] base, input logic [10:0] n);
    logic [31:0] s = 0;
    if (n < 2) return 32'd0;
    for (int i = 0; i < int'(n); i++) s += {16'd0, ram[base + 10'(i)]};
    if (CLOSE != 0) s += {16'd0, ram[base]};
    return s;
  endfunction

  // driver: issue one command, follow the burst, hold off res_ready, then complete the handshake
  task automatic do_cmd(input logic [9:0] base, input logic [10:0] n, input logic exp_err,
                        input logic [31:0] exp_surf, input int delay, input bit spur);
    int exp_len, rd_cnt, en_cnt, rises, first_en, cyc, hold_bad, idle_bad;
    bit got, prev_en;
    logic [31:0] held;
    exp_len = (n >= 2) ? int'(n) + CLOSE : 0;
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < int'(n) && n >= 2; i++) begin
      exp_addr_q.push_back(base + 10'(i));
      exp_q.push_back(ram[base + 10'(i)]);
    end
    if (n >= 2 && CLOSE != 0) exp_q.push_back(ram[base]);
    rd_cnt = 0; en_cnt = 0; rises = 0; first_en = -1; got = 0; prev_en = 0;

    @(negedge clk);
    start = 1'b1; base_addr = base; num_samples = n;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1);
    cyc = 1;
    while (cyc <= int'(n) + 40) begin
      if (mem_rd_en) begin
        rd_cnt++;
        if (exp_addr_q.size() > 0) check("mem_addr", mem_addr, exp_addr_q.pop_front());
        else check("mem_rd_extra", rd_cnt, n);
      end
      if (calc_en) begin
        if (!prev_en) rises++;
        if (first_en < 0) first_en = cyc;
        en_cnt++;
        if (exp_q.size() > 0) check("calc_radius", calc_radius, exp_q.pop_front());
        else check("calc_en_extra", en_cnt, exp_len);
      end
      prev_en = calc_en;
      if (spur && cyc == 3) begin
        start = 1'b1; base_addr = base ^ 10'h155; num_samples = 11'd5;
      end
      if (cyc == 4) start = 1'b0;
      if (res_valid) begin
        got = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("res_valid_seen", got, 1);
    check("res_err", res_err, exp_err);
    check("res_surf", res_surf, exp_surf);
    check("calc_en_len", en_cnt, exp_len);
    check("mem_rd_len", rd_cnt, (n >= 2) ? int'(n) : 0);
    check("calc_en_bursts", rises, (exp_len > 0) ? 1 : 0);
    if (exp_len > 0) check("calc_en_start", first_en, 2);
    check("busy_in_out", busy, 1);

    hold_bad = 0;
    held = res_surf;
    for (int i = 0; i < delay; i++) begin
      if (!res_valid || res_surf !== held || !busy || res_err !== exp_err || mem_rd_en || calc_en) hold_bad++;
      if (spur && i == 0) begin
        start = 1'b1; base_addr = base + 10'd3; num_samples = 11'd6;
      end
      if (i == 1) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("out_hold", hold_bad, 0);

    res_ready = 1'b1;
    if (spur) begin
      start = 1'b1; base_addr = base; num_samples = 11'd4;
    end
    @(negedge clk);
    res_ready = 1'b0;
    start = 1'b0;
    check("res_valid_after_hs", res_valid, 0);
    check("busy_after_hs", busy, 0);
    idle_bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (busy || mem_rd_en || calc_en || res_valid) idle_bad++;
    end
    check("idle_after_hs", idle_bad, 0);
  endtask

  typedef struct {
    logic [9:0]  base;
    logic [10:0] n;
    logic        exp_err;
    logic [31:0] exp_surf;
    int          delay;
    bit          spur;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int en_seen, bad;
    logic [9:0]  rb;
    logic [10:0] rn;
    for (int i = 0; i < 1024; i++) ram[i] = 16'($urandom);
    ram[0] = 16'd10; ram[1] = 16'd20; ram[2] = 16'd30; ram[3] = 16'd40;
    ram[1022] = 16'd5; ram[1023] = 16'd6;

    vecs[0] = '{10'd0,    11'd4,    1'b0, 32'(100 + 10 * CLOSE), 0,  1'b0};
    vecs[1] = '{10'd1022, 11'd4,    1'b0, 32'(41 + 5 * CLOSE),   2,  1'b0};
    vecs[2] = '{10'd0,    11'd1,    1'b1, 32'd0,                 1,  1'b0};
    vecs[3] = '{10'd9,    11'd0,    1'b1, 32'd0,                 0,  1'b0};
    vecs[4] = '{10'd100,  11'd6,    1'b0, model_sum(10'd100, 11'd6),  20, 1'b1};
    vecs[5] = '{10'd500,  11'd2,    1'b0, model_sum(10'd500, 11'd2),  0,  1'b0};
    vecs[6] = '{10'd7,    11'd2047, 1'b0, model_sum(10'd7, 11'd2047), 1,  1'b0};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_calc_en", calc_en, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_err", res_err, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_calc_radius", calc_radius, 0);
    check("rst_res_surf", res_surf, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 7; v++)
      do_cmd(vecs[v].base, vecs[v].n, vecs[v].exp_err, vecs[v].exp_surf, vecs[v].delay, vecs[v].spur);

    // reset in the middle of a burst
    @(negedge clk);
    start = 1'b1; base_addr = 10'd200; num_samples = 11'd8;
    @(negedge clk);
    start = 1'b0;
    en_seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (calc_en) en_seen++;
      if (en_seen == 3) break;
      @(negedge clk);
    end
    check("rst_mid_reached", en_seen, 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_calc_en", calc_en, 0);
    check("rst_mid_mem_rd_en", mem_rd_en, 0);
    check("rst_mid_busy", busy, 0);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (res_valid || calc_en || mem_rd_en || busy) bad++;
    end
    check("rst_mid_quiet", bad, 0);
    do_cmd(10'd300, 11'd2, 1'b0, model_sum(10'd300, 11'd2), 0, 1'b0);

    // random commands against the reference model
    for (int k = 0; k < 15; k++) begin
      rb = 10'($urandom_range(0, 1023));
      rn = 11'($urandom_range(0, 24));
      do_cmd(rb, rn, rn < 2, model_sum(rb, rn), $urandom_range(0, 4), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
